mdu_unit: RTL

- Multiply/divide unit attached to the EX stage of the 5-stage MIPS pipeline. It consumes the forwarded rs/rt operands of mult, multu, div, divu, mthi, mtlo and owns the HI/LO registers read by mfhi/mflo.
- It is a multi-cycle unit. The decode-stage hazard logic stalls any md-class instruction on the stall_req output.

---
 rtl/mdu_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO and holds results in a pending
// pair until the modelled multi-cycle latency has elapsed.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    logic [31:0]      ph;
    logic [31:0]      pl;
    logic             pw;
    logic [63:0]      mul_res;
    logic [63:0]      div_res;

    function automatic logic [63:0] mul_full(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] prod;
        sx   = sgn ? {{32{x[31]}}, x} : {32'b0, x};
        sy   = sgn ? {{32{y[31]}}, y} : {32'b0, y};
        prod = sx * sy;
        return prod;
    endfunction

    // Magnitude division avoids the 0x80000000 / -1 overflow of native signed divide.
    function automatic logic [63:0] div_full(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
        logic        neg_x;
        logic        neg_y;
        logic [31:0] ux;
        logic [31:0] uy;
        logic [31:0] q;
        logic [31:0] r;
        neg_x = sgn & x[31];
        neg_y = sgn & y[31];
        ux    = neg_x ? (~x + 32'd1) : x;
        uy    = neg_y ? (~y + 32'd1) : y;
        q     = 32'd0;
        r     = 32'd0;
        if (uy != 32'd0) begin
            q = ux / uy;
            r = ux % uy;
        end
        if (neg_x ^ neg_y) q = ~q + 32'd1;
        if (neg_x)         r = ~r + 32'd1;
        return {r, q};
    endfunction

    always_comb begin
        mul_res = mul_full(a, b, ~op[0]);
        div_res = div_full(a, b, ~op[0]);
    end

    assign busy      = (state == RUN);
    assign stall_req = busy | (start & ~op[2]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            ph    <= '0;
            pl    <= '0;
            pw    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1: begin
                                ph    <= mul_res[63:32];
                                pl    <= mul_res[31:0];
                                pw    <= 1'b1;
                                count <= CNT_W'(MULT_CYCLES);
                                state <= RUN;
                            end
                            3'd2, 3'd3: begin
                                ph    <= div_res[63:32];
                                pl    <= div_res[31:0];
                                pw    <= (b != 32'd0);
                                count <= CNT_W'(DIV_CYCLES);
                                state <= RUN;
                            end
                            3'd4:    hi <= a;
                            3'd5:    lo <= a;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        // Divide-by-zero leaves HI/LO untouched after the full latency.
                        if (pw) begin
                            hi <= ph;
                            lo <= pl;
                        end
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
